// File: rtl/ksa_serial_add16.sv
// Nibble-serial WIDTH-bit adder: one 4-bit Kogge-Stone slice reused N=WIDTH/4 times,
// LSB nibble first, with the inter-nibble carry held in a register.
module ksa_serial_add16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   areg, breg, acc, acc_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [3:0]         a_nib, b_nib, sum_nib;
  logic               cout_nib;
  logic               last_nib;

  // 4-bit Kogge-Stone: incoming carry is folded into g[0] so two prefix
  // levels (distance 1, then 2) span the whole nibble including carry-in.
  function automatic logic [4:0] ksa4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] p, g, g1, g2;
    logic       p1_2, p1_3;
    p     = a ^ b;
    g     = a & b;
    g[0]  = g[0] | (p[0] & ci);
    g1[0] = g[0];
    g1[1] = g[1] | (p[1] & g[0]);
    g1[2] = g[2] | (p[2] & g[1]);
    g1[3] = g[3] | (p[3] & g[2]);
    p1_2  = p[2] & p[1];
    p1_3  = p[3] & p[2];
    g2[0] = g1[0];
    g2[1] = g1[1];
    g2[2] = g1[2] | (p1_2 & g1[0]);
    g2[3] = g1[3] | (p1_3 & g1[1]);
    return {g2[3], p ^ {g2[2], g2[1], g2[0], ci}};
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last_nib  = (idx == IDX_W'(N - 1));

  always_comb begin
    a_nib               = areg[4*idx +: 4];
    b_nib               = breg[4*idx +: 4];
    {cout_nib, sum_nib} = ksa4(a_nib, b_nib, carry);
    acc_nxt             = acc;
    acc_nxt[4*idx +: 4] = sum_nib;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: capture in IDLE, one nibble per edge in RUN, publish on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      acc   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            areg  <= A;
            breg  <= B;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= cout_nib;
          idx   <= idx + IDX_W'(1);
          if (last_nib) begin
            S    <= acc_nxt;
            Cout <= cout_nib;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ksa_serial_add16.md
Name: ksa_serial_add16

Overview:
Multi-cycle wide adder built around a 4-bit Kogge-Stone carry-prefix slice. It accepts two WIDTH-bit operands over a valid/ready handshake and processes one nibble per clock, LSB first. The carry of each nibble is registered and chained into the next nibble. The block sits directly upstream of result consumers and presents a registered WIDTH-bit sum plus carry-out on a second valid/ready handshake.

Parameters:
WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand offer
in_ready  output  1  block can accept operands
A  input  WIDTH  operand A
B  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
S  output  WIDTH  registered sum
Cout  output  1  registered carry-out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset (rst=1 at an edge): state<=IDLE, nibble index<=0, carry reg<=0, operand regs<=0, S<=0, Cout<=0. out_valid=0 and busy=0. in_ready=0 while rst is high.
- States: IDLE, RUN, DONE. Outputs decode from state: in_ready=(state==IDLE)&&!rst; out_valid=(state==DONE); busy=(state!=IDLE).
- IDLE: on an edge with in_valid&&in_ready, capture A, B, cin into operand regs and the carry reg, set idx<=0, go to RUN. Otherwise hold. A, B and cin are ignored when in_ready=0.
- RUN, each edge:
  - Slice: a=Areg[4*idx+3:4*idx], b=Breg[4*idx+3:4*idx].
  - Compute p=a^b and g=a&b.
  - Run a 2-level Kogge-Stone prefix (distance 1, then 2) with the carry reg folded in as the generate term below bit 0.
  - Nibble sum = p ^ {c3,c2,c1,carry}. Write it into the accumulator at nibble idx; carry<=nibble carry-out; idx<=idx+1.
  - When idx==N-1, load S<=final accumulator (including this nibble), load Cout<=nibble carry-out, and go to DONE.
- Latency: operands accepted at edge t; out_valid rises after edge t+N (N=4 for default WIDTH). RUN occupies exactly N edges.
- DONE: S and Cout are stable and out_valid=1. in_ready=0, so no overlap or bypass. On an edge with out_ready=1, go to IDLE. S and Cout keep their value until the next result is loaded.
- Throughput: minimum N+2 cycles per operation (accept, N steps, 1 handshake cycle returning to IDLE).
- Simultaneous events: rst overrides everything. out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset mid-RUN or mid-DONE: abort the operation and discard the partial result. S/Cout clear to 0. The block is back in IDLE with in_ready=1 on the first cycle after rst deasserts.
- Arithmetic: {Cout,S} == A+B+cin, modulo 2^(WIDTH+1). There is no signed interpretation and no overflow flag.

Test Plan:
1. Reset, then A=16'h1234, B=16'h4321, cin=0 accepted at edge t -> out_valid high after edge t+4; S=16'h5555, Cout=0; busy high over edges t..t+5.
2. A=16'hFFFF, B=16'h0001, cin=0 -> S=16'h0000, Cout=1; carry propagates through all 4 nibbles. A=16'hFFFF, B=16'hFFFF, cin=1 -> S=16'hFFFF, Cout=1.
3. Backpressure: hold out_ready=0 for 3 cycles in DONE -> S, Cout and out_valid held constant, in_ready=0. A second in_valid with A=16'h0001, B=16'h0001 is not captured. After out_ready=1 the block returns to IDLE and the earlier result is unchanged.
4. Reset mid-RUN: assert rst for one edge after nibble 2 of A=16'h8000, B=16'h8000 -> out_valid never rises and S=0. Next op A=16'h00FF, B=16'h0001 -> S=16'h0100, Cout=0.
5. Back-to-back: in_valid held high with out_ready=1 -> the second operand set is accepted on the IDLE cycle following DONE, giving a 6-cycle spacing between accepts. Results are correct for A=16'h7FFF+B=16'h0001 (S=16'h8000, Cout=0) followed by A=16'hABCD+B=16'h5432, cin=1 (S=16'h0000, Cout=1).
6. Randomized self-check: 1000 random A/B/cin with random out_ready stalls -> every result matches A+B+cin, and no handshake is lost or duplicated.
